// File: rtl/player_move_if.sv
// Shared vector types and the frame request/result bus of the player_move stepper,
// including the combinational tile-solidity probe the stepper drives each cycle.
package player_move_pkg;
  typedef struct packed {
    logic signed [31:0] y;
    logic signed [31:0] x;
  } vec2d_t;

  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } vec2dint_t;
endpackage

interface player_move_if;
  import player_move_pkg::*;

  logic               start;
  vec2dint_t          pos_i;
  vec2d_t             rem_i;
  vec2d_t             spd_i;
  vec2dint_t          pos_o;
  vec2d_t             rem_o;
  vec2d_t             spd_o;
  logic               busy;
  logic               done;
  logic               clamped;
  // Tile map lookup: solid_i must answer the probe point in the same cycle.
  logic signed [15:0] probe_x_o;
  logic signed [15:0] probe_y_o;
  logic               solid_i;

  modport master (
    output start, pos_i, rem_i, spd_i, solid_i,
    input  pos_o, rem_o, spd_o, busy, done, clamped, probe_x_o, probe_y_o
  );

  modport slave (
    input  start, pos_i, rem_i, spd_i, solid_i,
    output pos_o, rem_o, spd_o, busy, done, clamped, probe_x_o, probe_y_o
  );
endinterface

// File: rtl/player_move.sv
// Sub-pixel integrator and collision stepper: rounds Q16.16 speed into whole pixels,
// then walks one pixel per cycle, X then Y, stopping an axis at the first solid tile.
module player_move
  import player_move_pkg::*;
#(
  parameter int HITBOX_X = 1,
  parameter int HITBOX_Y = 3,
  parameter int MAX_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  player_move_if.slave bus
);

  localparam int                 CW    = $clog2(MAX_STEP + 1);
  localparam logic signed [15:0] HB_X  = 16'(HITBOX_X);
  localparam logic signed [15:0] HB_Y  = 16'(HITBOX_Y);
  localparam logic signed [31:0] MAX_S = 32'(MAX_STEP);

  typedef enum logic [2:0] {IDLE, X_ROUND, X_STEP, Y_ROUND, Y_STEP, DONE} state_e;

  state_e             state_q, state_d;
  vec2dint_t          pos_q, pos_d;
  vec2d_t             rem_q, rem_d;
  vec2d_t             spd_q, spd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dir_neg_q, dir_neg_d;
  logic               clamp_q, clamp_d;

  vec2dint_t          pos_o_q;
  vec2d_t             rem_o_q, spd_o_q;
  logic               clamped_o_q, done_q;

  logic               axis_y, over;
  logic signed [31:0] r, rr, amt, amt_c, amt_abs, rem_new;
  logic [CW-1:0]      cnt_new;
  logic signed [15:0] dir, step_x, step_y;

  // Rounding datapath, shared by both axes; the active axis follows the state.
  always_comb begin
    axis_y  = (state_q == Y_ROUND) || (state_q == Y_STEP);
    r       = axis_y ? (rem_q.y + spd_q.y) : (rem_q.x + spd_q.x);
    rr      = r + 32'sh0000_8000;
    amt     = rr >>> 16;
    rem_new = r - (amt <<< 16);
    over    = 1'b0;
    amt_c   = amt;
    if (amt > MAX_S) begin
      amt_c = MAX_S;
      over  = 1'b1;
    end else if (amt < -MAX_S) begin
      amt_c = -MAX_S;
      over  = 1'b1;
    end
    amt_abs = amt_c[31] ? -amt_c : amt_c;
    cnt_new = CW'(amt_abs);
    dir     = dir_neg_q ? -16'sd1 : 16'sd1;
    step_x  = axis_y ? 16'sd0 : dir;
    step_y  = axis_y ? dir : 16'sd0;
  end

  assign bus.probe_x_o = pos_q.x + HB_X + step_x;
  assign bus.probe_y_o = pos_q.y + HB_Y + step_y;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    spd_d     = spd_q;
    cnt_d     = cnt_q;
    dir_neg_d = dir_neg_q;
    clamp_d   = clamp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pos_d   = bus.pos_i;
          rem_d   = bus.rem_i;
          spd_d   = bus.spd_i;
          cnt_d   = '0;
          clamp_d = 1'b0;
          state_d = X_ROUND;
        end
      end
      X_ROUND, Y_ROUND: begin
        if (axis_y) rem_d.y = rem_new;
        else        rem_d.x = rem_new;
        cnt_d     = cnt_new;
        dir_neg_d = amt_c[31];
        clamp_d   = clamp_q | over;
        if (cnt_new == '0) state_d = axis_y ? DONE : Y_ROUND;
        else               state_d = axis_y ? Y_STEP : X_STEP;
      end
      X_STEP, Y_STEP: begin
        if (bus.solid_i) begin
          // Blocked: kill this axis's motion and abandon the remaining pixels.
          if (axis_y) begin
            spd_d.y = '0;
            rem_d.y = '0;
          end else begin
            spd_d.x = '0;
            rem_d.x = '0;
          end
          state_d = axis_y ? DONE : Y_ROUND;
        end else begin
          pos_d.x = pos_q.x + step_x;
          pos_d.y = pos_q.y + step_y;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = axis_y ? DONE : Y_ROUND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: working registers are reset too, so an aborted frame leaves nothing stale.
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      rem_q       <= '0;
      spd_q       <= '0;
      cnt_q       <= '0;
      dir_neg_q   <= 1'b0;
      clamp_q     <= 1'b0;
      pos_o_q     <= '0;
      rem_o_q     <= '0;
      spd_o_q     <= '0;
      clamped_o_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      spd_q     <= spd_d;
      cnt_q     <= cnt_d;
      dir_neg_q <= dir_neg_d;
      clamp_q   <= clamp_d;
      done_q    <= (state_d == DONE);
      if (state_d == DONE) begin
        pos_o_q     <= pos_d;
        rem_o_q     <= rem_d;
        spd_o_q     <= spd_d;
        clamped_o_q <= clamp_d;
      end
    end
  end

  assign bus.pos_o   = pos_o_q;
  assign bus.rem_o   = rem_o_q;
  assign bus.spd_o   = spd_o_q;
  assign bus.clamped = clamped_o_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_player_move.sv
// Scoreboard bench for player_move: expectations are queued when a frame starts
// and compared when done pulses; the tile map is a few configurable walls.
module tb_player_move;
  import player_move_pkg::*;

  typedef struct {
    vec2dint_t pos;
    vec2d_t    rem;
    vec2d_t    spd;
    logic      clamped;
    int        lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  player_move_if bus();

  player_move #(.HITBOX_X(1), .HITBOX_Y(3), .MAX_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Tile map: solid right of wall_x, left of wall_lo, and at/below floor_y.
  int wall_x  = 30000;
  int wall_lo = -30000;
  int floor_y = 30000;

  assign bus.solid_i = (int'(bus.probe_x_o) >= wall_x) || (int'(bus.probe_x_o) < wall_lo) ||
                       (int'(bus.probe_y_o) >= floor_y);

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec2dint_t vi(input int x, input int y);
    vi.x = 16'(x);
    vi.y = 16'(y);
  endfunction

  function automatic vec2d_t vq(input logic [31:0] x, input logic [31:0] y);
    vq.x = x;
    vq.y = y;
  endfunction

  function automatic bit tile_solid(input logic signed [15:0] x, input logic signed [15:0] y);
    return (int'(x) >= wall_x) || (int'(x) < wall_lo) || (int'(y) >= floor_y);
  endfunction

  // Reference behaviour written from the frame algorithm, using integer floor division.
  function automatic exp_t model(input vec2dint_t p, input vec2d_t rm, input vec2d_t sp);
    exp_t               e;
    logic signed [31:0] r, rr, rn;
    logic signed [15:0] d, qx, qy;
    longint             lr, a, n;
    e.pos = p; e.rem = rm; e.spd = sp; e.clamped = 1'b0; e.lat = 3;
    for (int ax = 0; ax < 2; ax++) begin
      r  = (ax == 1) ? (e.rem.y + e.spd.y) : (e.rem.x + e.spd.x);
      rr = r + 32'sh8000;
      lr = longint'(rr);
      if (lr >= 0) a = lr / 65536;
      else         a = -((-lr + 65535) / 65536);
      rn = r - 32'(a * 65536);
      if (ax == 1) e.rem.y = rn; else e.rem.x = rn;
      if (a > 8)  begin a = 8;  e.clamped = 1'b1; end
      if (a < -8) begin a = -8; e.clamped = 1'b1; end
      n = (a < 0) ? -a : a;
      d = (a < 0) ? -16'sd1 : 16'sd1;
      for (longint k = 0; k < n; k++) begin
        qx = (ax == 1) ? e.pos.x + 16'sd1 : e.pos.x + 16'sd1 + d;
        qy = (ax == 1) ? e.pos.y + 16'sd3 + d : e.pos.y + 16'sd3;
        e.lat++;
        if (tile_solid(qx, qy)) begin
          if (ax == 1) begin e.spd.y = '0; e.rem.y = '0; end
          else         begin e.spd.x = '0; e.rem.x = '0; end
          break;
        end
        if (ax == 1) e.pos.y = e.pos.y + d; else e.pos.x = e.pos.x + d;
      end
    end
    return e;
  endfunction

  task automatic run_frame(input vec2dint_t p, input vec2d_t rm, input vec2d_t sp, input bit poke);
    exp_t e;
    int   lat;
    int   extra;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pos_i = p; bus.rem_i = rm; bus.spd_i = sp;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.pos_i = vi(-5, 77); bus.rem_i = vq(32'h1234, 32'h4321);
    bus.spd_i = vq(32'h30000, 32'hFFFD0000);
    lat = 1;
    check("busy_after_start", bus.busy, 1'b1);
    while (!bus.done && lat < 40) begin
      bus.start = poke && (lat == 1);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!bus.done) begin
      check("done_timeout", 1'b0, 1'b1);
    end else begin
      check("latency", 64'(lat), 64'(e.lat));
      check("pos_x", bus.pos_o.x, e.pos.x);
      check("pos_y", bus.pos_o.y, e.pos.y);
      check("rem_x", bus.rem_o.x, e.rem.x);
      check("rem_y", bus.rem_o.y, e.rem.y);
      check("spd_x", bus.spd_o.x, e.spd.x);
      check("spd_y", bus.spd_o.y, e.spd.y);
      check("clamped", bus.clamped, e.clamped);
      check("busy_at_done", bus.busy, 1'b0);
    end
    if (poke) begin
      extra = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      check("ignored_start_no_done", 64'(extra), 64'd0);
    end
  endtask

  initial begin
    vec2dint_t p;
    vec2d_t    rm, sp;
    int        dones;

    rst = 1'b1;
    bus.start = 1'b0; bus.pos_i = '0; bus.rem_i = '0; bus.spd_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", bus.pos_o, 32'h0);
    check("rst_rem", bus.rem_o, 64'h0);
    check("rst_spd", bus.spd_o, 64'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_clamped", bus.clamped, 1'b0);
    rst = 1'b0;

    // Plain X move of 1.5 px rounds to 2 px.
    sb.push_back('{pos: vi(42, 40), rem: vq(32'hFFFF8000, 0), spd: vq(32'h18000, 0), clamped: 1'b0, lat: 5});
    run_frame(vi(40, 40), vq(0, 0), vq(32'h18000, 0), 1'b0);

    // Remainder carry reaches exactly half a pixel.
    sb.push_back('{pos: vi(41, 40), rem: vq(32'hFFFF8000, 0), spd: vq(32'h1000, 0), clamped: 1'b0, lat: 4});
    run_frame(vi(40, 40), vq(32'h7000, 0), vq(32'h1000, 0), 1'b0);

    // Standing on the floor: first Y probe is solid.
    floor_y = 44;
    sb.push_back('{pos: vi(40, 40), rem: vq(0, 0), spd: vq(0, 0), clamped: 1'b0, lat: 4});
    run_frame(vi(40, 40), vq(0, 0), vq(0, 32'h20000), 1'b0);
    floor_y = 30000;

    // Wall two pixels right of the probe stops the walk after one pixel.
    wall_x = 43;
    sb.push_back('{pos: vi(41, 40), rem: vq(0, 0), spd: vq(0, 0), clamped: 1'b0, lat: 5});
    run_frame(vi(40, 40), vq(0, 0), vq(32'h40000, 0), 1'b0);
    wall_x = 30000;

    // -12 px clamps to -8 px.
    sb.push_back('{pos: vi(32, 40), rem: vq(0, 0), spd: vq(32'hFFF40000, 0), clamped: 1'b1, lat: 11});
    run_frame(vi(40, 40), vq(0, 0), vq(32'hFFF40000, 0), 1'b0);

    // start pulsed while busy is ignored.
    sb.push_back('{pos: vi(42, 40), rem: vq(32'hFFFF8000, 0), spd: vq(32'h18000, 0), clamped: 1'b0, lat: 5});
    run_frame(vi(40, 40), vq(0, 0), vq(32'h18000, 0), 1'b1);

    // Reset during X_STEP aborts the frame.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pos_i = vi(40, 40); bus.rem_i = '0; bus.spd_i = vq(32'h40000, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("in_x_step_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_pos", bus.pos_o, 32'h0);
    check("abort_rem", bus.rem_o, 64'h0);
    check("abort_spd", bus.spd_o, 64'h0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_clamped", bus.clamped, 1'b0);
    dones = 0;
    repeat (12) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Normal frame after the abort.
    sb.push_back('{pos: vi(42, 40), rem: vq(32'hFFFF8000, 0), spd: vq(32'h18000, 0), clamped: 1'b0, lat: 5});
    run_frame(vi(40, 40), vq(0, 0), vq(32'h18000, 0), 1'b0);

    // Randomised back-to-back frames against the reference model.
    for (int i = 0; i < 30; i++) begin
      p  = vi(int'($urandom_range(100, 200)), int'($urandom_range(100, 200)));
      rm = vq(32'(int'($urandom_range(0, 32'h10000)) - 32'h8000),
              32'(int'($urandom_range(0, 32'h10000)) - 32'h8000));
      sp = vq(32'(int'($urandom_range(0, 32'h140000)) - 32'hA0000),
              32'(int'($urandom_range(0, 32'h140000)) - 32'hA0000));
      wall_x  = int'(p.x) + 1 + int'($urandom_range(1, 12));
      wall_lo = int'(p.x) + 1 - int'($urandom_range(0, 12));
      floor_y = int'(p.y) + 3 + int'($urandom_range(1, 12));
      sb.push_back(model(p, rm, sp));
      run_frame(p, rm, sp, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
